// File: rtl/paddle_ctrl_pkg.sv
// rtl/paddle_ctrl_pkg.sv - shared mode encoding, position limits and saturating helpers for paddle_ctrl
package paddle_ctrl_pkg;

  typedef enum logic [1:0] {
    MODE_DIGITAL = 2'b00,
    MODE_ANALOG  = 2'b01,
    MODE_SPINNER = 2'b10,
    MODE_HOLD    = 2'b11
  } mode_e;

  localparam logic [7:0] POS_RESET = 8'd128;
  localparam logic [7:0] POS_MIN   = 8'd0;
  localparam logic [7:0] POS_MAX   = 8'd255;

  localparam logic signed [7:0] DELTA_MAX = 8'sd127;
  localparam logic signed [7:0] DELTA_MIN = -8'sd127;

  // Synced _v256 must stay high this many cycles before another fall may tick,
  // so a glitchy flag cannot produce two updates in one frame.
  localparam int REARM_CYCLES = 64;

  function automatic logic [7:0] sat_pos(input logic [7:0] pos, input logic signed [9:0] inc);
    logic signed [9:0] sum;
    sum = $signed({2'b00, pos}) + inc;
    if (sum < $signed({2'b00, POS_MIN})) begin
      return POS_MIN;
    end else if (sum > $signed({2'b00, POS_MAX})) begin
      return POS_MAX;
    end else begin
      return sum[7:0];
    end
  endfunction

  function automatic logic signed [7:0] sat_delta(input logic signed [7:0] d, input logic inc);
    if (inc) begin
      return (d == DELTA_MAX) ? d : d + 8'sd1;
    end else begin
      return (d == DELTA_MIN) ? d : d - 8'sd1;
    end
  endfunction

endpackage

// File: rtl/paddle_ctrl_quad_decoder.sv
// rtl/paddle_ctrl_quad_decoder.sv - quadrature decoder, one step pulse per legal Gray transition
module quad_decoder
  import paddle_ctrl_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic a,
  input  logic b,
  output logic step,
  output logic dir
);

  logic [1:0] ab_q;
  logic [1:0] ab_d;
  logic [1:0] ab_chg;

  always_comb begin
    ab_d   = {a, b};
    ab_chg = ab_d ^ ab_q;
    step   = 1'b0;
    dir    = 1'b0;
    // A double change is ignored; ab_q still takes the new value so decoding resyncs.
    if (ab_chg == 2'b01 || ab_chg == 2'b10) begin
      step = 1'b1;
      dir  = ab_q[0] ^ a;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ab_q <= 2'b00;
    end else begin
      ab_q <= ab_d;
    end
  end

endmodule

// File: rtl/paddle_ctrl.sv
// rtl/paddle_ctrl.sv - per-player paddle position front end, updated once per frame at vblank start
module paddle_ctrl
  import paddle_ctrl_pkg::*;
#(
  parameter int SYNC_STAGES  = 2,
  parameter int SPEED_MIN    = 1,
  parameter int SPEED_MAX    = 6,
  parameter int ACCEL_FRAMES = 4,
  parameter int SPIN_SHIFT   = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] mode,
  input  logic       _v256,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic [7:0] analog_y,
  input  logic       spin_a,
  input  logic       spin_b,
  output logic [7:0] paddle_vpos,
  output logic       frame_tick
);

  logic [SYNC_STAGES-1:0][4:0] sync_q, sync_d;
  logic v256_s, up_s, down_s, a_s, b_s;

  logic        v256_prev_q, v256_prev_d;
  logic        armed_q, armed_d;
  logic [7:0]  rearm_q, rearm_d;
  logic        frame_tick_q, frame_tick_d;
  mode_e       mode_q, mode_d;
  logic [7:0]  pos_q, pos_d;
  logic [7:0]  speed_q, speed_d;
  logic [7:0]  hold_q, hold_d;
  logic        last_down_q, last_down_d;
  logic signed [7:0] delta_q, delta_d;

  logic        q_step, q_dir;
  logic        fall;
  mode_e       mode_in, acc_mode;
  logic        mode_chg;
  logic        fresh;
  logic [7:0]  step_spd;
  logic [7:0]  hold_nxt;
  logic signed [7:0] delta_base;
  logic signed [7:0] delta_cur;
  logic signed [9:0] inc;

  assign {v256_s, up_s, down_s, a_s, b_s} = sync_q[SYNC_STAGES-1];

  quad_decoder u_quad (
    .clk   (clk),
    .reset (reset),
    .a     (a_s),
    .b     (b_s),
    .step  (q_step),
    .dir   (q_dir)
  );

  always_comb begin
    sync_d      = {sync_q[SYNC_STAGES-2:0], {_v256, btn_up, btn_down, spin_a, spin_b}};
    v256_prev_d = v256_s;

    fall         = armed_q & v256_prev_q & ~v256_s;
    frame_tick_d = fall;
    rearm_d      = v256_s ? ((rearm_q == 8'(REARM_CYCLES)) ? rearm_q : rearm_q + 8'd1) : 8'd0;
    armed_d      = armed_q;
    if (fall) begin
      armed_d = 1'b0;
    end else if (rearm_q == 8'(REARM_CYCLES)) begin
      armed_d = 1'b1;
    end

    mode_in     = mode_e'(mode);
    mode_chg    = (mode_in != mode_q);
    mode_d      = mode_q;
    pos_d       = pos_q;
    speed_d     = speed_q;
    hold_d      = hold_q;
    last_down_d = last_down_q;
    fresh       = 1'b0;
    step_spd    = speed_q;
    hold_nxt    = hold_q;
    inc         = '0;
    delta_cur   = (frame_tick_q && mode_chg) ? 8'sd0 : delta_q;

    if (frame_tick_q) begin
      mode_d  = mode_in;
      speed_d = 8'(SPEED_MIN);
      hold_d  = 8'd0;
      case (mode_in)
        MODE_DIGITAL: begin
          if (up_s ^ down_s) begin
            // Starting, reversing or entering the mode all restart the ramp at SPEED_MIN.
            fresh    = mode_chg || (down_s != last_down_q);
            step_spd = fresh ? 8'(SPEED_MIN) : speed_q;
            hold_nxt = (fresh ? 8'd0 : hold_q) + 8'd1;
            inc      = down_s ? $signed({2'b00, step_spd}) : -$signed({2'b00, step_spd});
            pos_d    = sat_pos(pos_q, inc);
            last_down_d = down_s;
            if (hold_nxt == 8'(ACCEL_FRAMES)) begin
              speed_d = (step_spd >= 8'(SPEED_MAX)) ? 8'(SPEED_MAX) : step_spd + 8'd1;
              hold_d  = 8'd0;
            end else begin
              speed_d = step_spd;
              hold_d  = hold_nxt;
            end
          end
        end
        MODE_ANALOG: begin
          pos_d = {~analog_y[7], analog_y[6:0]};
        end
        MODE_SPINNER: begin
          inc   = $signed({{2{delta_cur[7]}}, delta_cur}) <<< SPIN_SHIFT;
          pos_d = sat_pos(pos_q, inc);
        end
        default: begin
        end
      endcase
    end

    // On the tick cycle the accumulator restarts from zero, so a concurrent step
    // belongs to the frame that is just beginning.
    acc_mode   = frame_tick_q ? mode_in : mode_q;
    delta_base = frame_tick_q ? 8'sd0 : delta_q;
    if (acc_mode == MODE_SPINNER) begin
      delta_d = q_step ? sat_delta(delta_base, q_dir) : delta_base;
    end else begin
      delta_d = 8'sd0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q       <= {SYNC_STAGES{5'b1_0000}};
      v256_prev_q  <= 1'b1;
      armed_q      <= 1'b1;
      rearm_q      <= 8'd0;
      frame_tick_q <= 1'b0;
      mode_q       <= MODE_HOLD;
      pos_q        <= POS_RESET;
      speed_q      <= 8'(SPEED_MIN);
      hold_q       <= 8'd0;
      last_down_q  <= 1'b0;
      delta_q      <= 8'sd0;
    end else begin
      sync_q       <= sync_d;
      v256_prev_q  <= v256_prev_d;
      armed_q      <= armed_d;
      rearm_q      <= rearm_d;
      frame_tick_q <= frame_tick_d;
      mode_q       <= mode_d;
      pos_q        <= pos_d;
      speed_q      <= speed_d;
      hold_q       <= hold_d;
      last_down_q  <= last_down_d;
      delta_q      <= delta_d;
    end
  end

  assign paddle_vpos = pos_q;
  assign frame_tick  = frame_tick_q;

endmodule

// File: tb/tb_paddle_ctrl.sv
// tb/tb_paddle_ctrl.sv - frame-level table and scoreboard bench for paddle_ctrl
module tb_paddle_ctrl;
  import paddle_ctrl_pkg::*;

  localparam int SYNC = 2;

  typedef struct {
    logic [1:0] mode;
    logic       up;
    logic       down;
    logic [7:0] ay;
    int         steps;
    bit         illegal;
    bit         tick_step;
    logic [7:0] exp;
  } vec_t;

  typedef struct {
    logic [7:0] exp;
    int         id;
  } sb_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] mode;
  logic       v256_n;
  logic       btn_up, btn_down;
  logic [7:0] analog_y;
  logic       spin_a, spin_b;
  logic [7:0] paddle_vpos;
  logic       frame_tick;

  int   n_cmp = 0;
  int   n_bad = 0;
  int   tick_cnt = 0;
  int   spin_s = 0;
  vec_t vecs[$];
  sb_t  sb_q[$];

  paddle_ctrl #(
    .SYNC_STAGES (SYNC),
    .SPEED_MIN   (1),
    .SPEED_MAX   (6),
    .ACCEL_FRAMES(4),
    .SPIN_SHIFT  (1)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .mode       (mode),
    ._v256      (v256_n),
    .btn_up     (btn_up),
    .btn_down   (btn_down),
    .analog_y   (analog_y),
    .spin_a     (spin_a),
    .spin_b     (spin_b),
    .paddle_vpos(paddle_vpos),
    .frame_tick (frame_tick)
  );

  always #5 clk = ~clk;

  function automatic void add(input logic [1:0] m, input logic u, input logic d, input logic [7:0] ay,
                              input int st, input bit ill, input bit ts, input logic [7:0] e);
    vec_t v;
    v.mode = m; v.up = u; v.down = d; v.ay = ay; v.steps = st;
    v.illegal = ill; v.tick_step = ts; v.exp = e;
    vecs.push_back(v);
  endfunction

  task automatic spin_edge(input int d);
    spin_s = (spin_s + d + 4) % 4;
    case (spin_s)
      0: {spin_a, spin_b} = 2'b00;
      1: {spin_a, spin_b} = 2'b10;
      2: {spin_a, spin_b} = 2'b11;
      default: {spin_a, spin_b} = 2'b01;
    endcase
  endtask

  task automatic spin_step(input int d);
    @(negedge clk);
    spin_edge(d);
    repeat (3) @(negedge clk);
  endtask

  task automatic monitor();
    logic       tick_d1;
    logic [7:0] prev_vpos;
    logic       prev_rst;
    sb_t        e;
    tick_d1   = 1'b0;
    prev_vpos = paddle_vpos;
    prev_rst  = reset;
    forever begin
      @(negedge clk);
      if (tick_d1) begin
        n_cmp++;
        if (sb_q.size() == 0) begin
          n_bad++;
          $display("FAIL unexpected_tick: paddle_vpos %0d with no expected update", paddle_vpos);
        end else begin
          e = sb_q.pop_front();
          if (paddle_vpos !== e.exp) begin
            n_bad++;
            $display("FAIL pos[%0d]: got %0d expected %0d", e.id, paddle_vpos, e.exp);
          end
        end
      end else if (!prev_rst) begin
        n_cmp++;
        if (paddle_vpos !== prev_vpos) begin
          n_bad++;
          $display("FAIL vpos_stable: got %0d expected %0d", paddle_vpos, prev_vpos);
        end
      end
      if (frame_tick) tick_cnt++;
      tick_d1   = frame_tick;
      prev_vpos = paddle_vpos;
      prev_rst  = reset;
    end
  endtask

  task automatic wait_tick(input string name, output bit got, output int lat);
    got = 1'b0;
    lat = 0;
    for (int c = 1; c <= 20 && !got; c++) begin
      @(negedge clk);
      if (frame_tick) begin
        got = 1'b1;
        lat = c;
      end
    end
    if (!got) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s_timeout: no frame_tick within 20 cycles, required one", name);
      if (sb_q.size() > 0) void'(sb_q.pop_back());
    end
  endtask

  task automatic run_frame(input vec_t v, input int id);
    int  n, d, lat;
    bit  got;
    mode = v.mode; btn_up = v.up; btn_down = v.down; analog_y = v.ay;
    n = (v.steps < 0) ? -v.steps : v.steps;
    d = (v.steps < 0) ? -1 : 1;
    for (int i = 0; i < n; i++) begin
      spin_step(d);
      if (v.illegal && i == 0) spin_step(2);
    end
    repeat (SYNC + 2) @(negedge clk);
    @(negedge clk);
    v256_n = 1'b0;
    sb_q.push_back('{v.exp, id});
    got = 1'b0;
    lat = 0;
    for (int c = 1; c <= 20 && !got; c++) begin
      @(negedge clk);
      if (v.tick_step && c == 1) spin_edge(1);
      if (frame_tick) begin
        got = 1'b1;
        lat = c;
      end
    end
    n_cmp++;
    if (!got) begin
      n_bad++;
      $display("FAIL tick_timeout[%0d]: no frame_tick within 20 cycles, required one", id);
      if (sb_q.size() > 0) void'(sb_q.pop_back());
    end else if (lat != SYNC + 1) begin
      n_bad++;
      $display("FAIL tick_latency[%0d]: got %0d cycles expected %0d", id, lat, SYNC + 1);
    end
    @(negedge clk);
    v256_n = 1'b1;
    repeat (80) @(negedge clk);
  endtask

  initial begin
    int  t0, lat;
    bit  got;

    reset = 1'b1; mode = 2'b11; v256_n = 1'b1; btn_up = 1'b0; btn_down = 1'b0;
    analog_y = 8'h00; spin_a = 1'b0; spin_b = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (paddle_vpos !== 8'd128) begin
      n_bad++; $display("FAIL reset_vpos: got %0d expected 128", paddle_vpos);
    end
    n_cmp++;
    if (frame_tick !== 1'b0) begin
      n_bad++; $display("FAIL reset_tick: got %0b expected 0", frame_tick);
    end
    reset = 1'b0;
    fork
      monitor();
    join_none
    repeat (4) @(negedge clk);

    // mode, up, down, analog_y, spinner steps, illegal, tick_step, expected pos
    add(2'b01, 0, 0, 8'h80, 0, 0, 0, 8'd0);
    add(2'b01, 0, 0, 8'h7F, 0, 0, 0, 8'd255);
    add(2'b01, 0, 0, 8'h00, 0, 0, 0, 8'd128);
    add(2'b00, 0, 1, 8'h00, 0, 0, 0, 8'd129);
    add(2'b00, 0, 1, 8'h00, 0, 0, 0, 8'd130);
    add(2'b00, 0, 1, 8'h00, 0, 0, 0, 8'd131);
    add(2'b00, 0, 1, 8'h00, 0, 0, 0, 8'd132);
    add(2'b00, 0, 1, 8'h00, 0, 0, 0, 8'd134);
    add(2'b00, 0, 1, 8'h00, 0, 0, 0, 8'd136);
    add(2'b00, 0, 1, 8'h00, 0, 0, 0, 8'd138);
    add(2'b00, 0, 1, 8'h00, 0, 0, 0, 8'd140);
    add(2'b00, 0, 1, 8'h00, 0, 0, 0, 8'd143);
    add(2'b00, 0, 1, 8'h00, 0, 0, 0, 8'd146);
    add(2'b00, 0, 1, 8'h00, 0, 0, 0, 8'd149);
    add(2'b00, 0, 1, 8'h00, 0, 0, 0, 8'd152);
    add(2'b00, 1, 0, 8'h00, 0, 0, 0, 8'd151);
    add(2'b01, 0, 0, 8'h83, 0, 0, 0, 8'd3);
    add(2'b00, 1, 0, 8'h00, 0, 0, 0, 8'd2);
    add(2'b00, 1, 0, 8'h00, 0, 0, 0, 8'd1);
    add(2'b00, 1, 0, 8'h00, 0, 0, 0, 8'd0);
    add(2'b00, 1, 0, 8'h00, 0, 0, 0, 8'd0);
    add(2'b00, 1, 0, 8'h00, 0, 0, 0, 8'd0);
    add(2'b00, 0, 1, 8'h00, 0, 0, 0, 8'd1);
    add(2'b00, 0, 1, 8'h00, 0, 0, 0, 8'd2);
    add(2'b00, 0, 1, 8'h00, 0, 0, 0, 8'd3);
    add(2'b00, 0, 1, 8'h00, 0, 0, 0, 8'd4);
    add(2'b00, 1, 1, 8'h00, 0, 0, 0, 8'd4);
    add(2'b00, 0, 1, 8'h00, 0, 0, 0, 8'd5);
    add(2'b00, 0, 0, 8'h00, 0, 0, 0, 8'd5);
    add(2'b01, 0, 0, 8'h00, 0, 0, 0, 8'd128);
    add(2'b10, 0, 0, 8'h00, 5, 0, 0, 8'd128);
    add(2'b10, 0, 0, 8'h00, 10, 0, 0, 8'd148);
    add(2'b10, 0, 0, 8'h00, -3, 1, 0, 8'd142);
    add(2'b10, 0, 0, 8'h00, 200, 0, 0, 8'd255);
    add(2'b10, 0, 0, 8'h00, -20, 0, 0, 8'd215);
    add(2'b10, 0, 0, 8'h00, 0, 0, 1, 8'd215);
    add(2'b10, 0, 0, 8'h00, 0, 0, 0, 8'd217);
    add(2'b11, 0, 0, 8'h00, 4, 0, 0, 8'd217);
    add(2'b10, 0, 0, 8'h00, 0, 0, 0, 8'd217);
    add(2'b00, 0, 1, 8'h00, 0, 0, 0, 8'd218);

    foreach (vecs[i]) run_frame(vecs[i], i);

    // Reset landing on the tick cycle: no increment, output back to 128.
    mode = 2'b00; btn_up = 1'b0; btn_down = 1'b1;
    repeat (SYNC + 2) @(negedge clk);
    v256_n = 1'b0;
    sb_q.push_back('{8'd128, 100});
    wait_tick("rst_tick", got, lat);
    if (got) begin
      reset = 1'b1;
      v256_n = 1'b1;
    end
    @(negedge clk);
    n_cmp++;
    if (frame_tick !== 1'b0) begin
      n_bad++; $display("FAIL rst_tick_clear: got %0b expected 0", frame_tick);
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    v256_n = 1'b1;
    repeat (80) @(negedge clk);
    n_cmp++;
    if (paddle_vpos !== 8'd128) begin
      n_bad++; $display("FAIL rst_hold: got %0d expected 128", paddle_vpos);
    end

    // Glitching _v256 1->0->1->0 within one frame must tick once.
    mode = 2'b01; analog_y = 8'h0A;
    repeat (SYNC + 2) @(negedge clk);
    t0 = tick_cnt;
    v256_n = 1'b0;
    sb_q.push_back('{8'd138, 101});
    wait_tick("glitch_tick", got, lat);
    repeat (3) @(negedge clk);
    v256_n = 1'b1;
    repeat (3) @(negedge clk);
    v256_n = 1'b0;
    repeat (20) @(negedge clk);
    n_cmp++;
    if (tick_cnt - t0 != 1) begin
      n_bad++; $display("FAIL glitch_ticks: got %0d expected 1", tick_cnt - t0);
    end
    v256_n = 1'b1;
    repeat (80) @(negedge clk);

    n_cmp++;
    if (sb_q.size() != 0) begin
      n_bad++; $display("FAIL sb_drain: got %0d pending expected 0", sb_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
